// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu_pkg: ALU control codes and op-class helpers shared by the multiply/divide unit.
package hilo_mdu_pkg;
  localparam logic [4:0] ALU_ADD           = 5'b00000;
  localparam logic [4:0] ALU_SIGNED_MULT   = 5'b10000;
  localparam logic [4:0] ALU_UNSIGNED_MULT = 5'b10001;
  localparam logic [4:0] ALU_SIGNED_DIV    = 5'b10010;
  localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'b10011;
  localparam logic [4:0] ALU_MTHI          = 5'b10100;
  localparam logic [4:0] ALU_MTLO          = 5'b10101;

  function automatic logic is_mul_op(input logic [4:0] op);
    return op == ALU_SIGNED_MULT || op == ALU_UNSIGNED_MULT;
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op == ALU_SIGNED_DIV || op == ALU_UNSIGNED_DIV;
  endfunction
endpackage

// File: rtl/hilo_mdu_div_radix2.sv
// div_radix2: unsigned restoring divider, one quotient bit per cycle over WIDTH cycles.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted, trial;
  assign shifted = {remainder, quotient[WIDTH-1]};
  // bit WIDTH of trial is the borrow: set when the shifted remainder is below the divisor
  assign trial = shifted - {1'b0, dvs};
  assign done  = cnt == CW'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvs       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      dvs       <= divisor;
      cnt       <= CW'(WIDTH);
      quotient  <= dividend;
      remainder <= '0;
    end else if (cnt != '0) begin
      cnt       <= cnt - 1'b1;
      remainder <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quotient  <= {quotient[WIDTH-2:0], ~trial[WIDTH]};
    end
  end
endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: EX-stage multiply/divide unit with its own HI/LO pair and pipeline stall.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, POST, DONE} state_t;
  localparam int CW = $clog2(MUL_LAT + 1);
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] pipe [MUL_LAT];
  logic [2*WIDTH-1:0] ma, mb;
  logic [WIDTH-1:0]   a_abs, b_abs, a_q, uq, ur, q_fix, r_fix;
  logic               accept, is_smul, is_sdiv, sa, neg_q, bz, div_done;
  assign is_smul = op_i == ALU_SIGNED_MULT;
  assign is_sdiv = op_i == ALU_SIGNED_DIV;
  assign accept  = !rst && state == IDLE && valid_i && !flush_i && (is_mul_op(op_i) || is_div_op(op_i));
  assign stall_o = accept || state == MUL || state == DIV || state == POST;
  assign ma      = {{WIDTH{is_smul & a_i[WIDTH-1]}}, a_i};
  assign mb      = {{WIDTH{is_smul & b_i[WIDTH-1]}}, b_i};
  assign a_abs   = (is_sdiv && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_abs   = (is_sdiv && b_i[WIDTH-1]) ? -b_i : b_i;
  assign q_fix   = neg_q ? -uq : uq;
  assign r_fix   = sa ? -ur : ur;
  div_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div_op(op_i)),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (uq),
    .remainder (ur),
    .done      (div_done)
  );
  // stage 0 captures the product only on accept, so later stages settle on it and hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    end else begin
      if (accept && is_mul_op(op_i)) pipe[0] <= ma * mb;
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_q        <= '0;
      sa         <= 1'b0;
      neg_q      <= 1'b0;
      bz         <= 1'b0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
    end else if (flush_i) begin
      state      <= IDLE;
      cnt        <= '0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o     <= 1'b0;
          div_zero_o <= 1'b0;
          if (accept) begin
            state <= is_mul_op(op_i) ? MUL : DIV;
            cnt   <= '0;
            a_q   <= a_i;
            sa    <= is_sdiv & a_i[WIDTH-1];
            neg_q <= is_sdiv & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            bz    <= b_i == '0;
          end else if (valid_i && op_i == ALU_MTHI) begin
            hi_o <= a_i;
          end else if (valid_i && op_i == ALU_MTLO) begin
            lo_o <= a_i;
          end
        end
        MUL: begin
          if (cnt == CW'(MUL_LAT - 1)) begin
            state  <= DONE;
            done_o <= 1'b1;
            hi_o   <= pipe[MUL_LAT-1][2*WIDTH-1:WIDTH];
            lo_o   <= pipe[MUL_LAT-1][WIDTH-1:0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: state <= div_done ? POST : DIV;
        POST: begin
          state      <= DONE;
          done_o     <= 1'b1;
          div_zero_o <= bz;
          hi_o       <= bz ? a_q : r_fix;
          lo_o       <= bz ? '1 : q_fix;
        end
        DONE: begin
          state      <= IDLE;
          done_o     <= 1'b0;
          div_zero_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
